mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified instruction/data memory port between the multicycle CPU
//  and a debug/loader requester. Fixed priority to CPU, with a starvation limit that
//  forces a debug grant. Sequences each access as IDLE->ISSUE->(WAIT)->RESP and returns
//  a one-cycle ack. Sits between the CPU memory interface (iord-muxed address) and the RAM.
// PARAMETERS
//  ADDR_W        32  address width, both requesters and memory
//  DATA_W        32  data width
//  MEM_LAT       1   cycles from ISSUE until mem_rd is valid (>=1)
//  STARVE_LIMIT  8   max cycles dbg_req waits before it preempts CPU priority (>=1)
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high
//  cpu_req    in   1       CPU access request, held until cpu_ack
//  cpu_addr   in   ADDR_W  CPU address
//  cpu_wd     in   DATA_W  CPU write data
//  cpu_we     in   2       00 read, 01 word write, 10 byte write, 11 illegal
//  cpu_rd     out  DATA_W  read data, valid while cpu_ack=1
//  cpu_ack    out  1       one-cycle completion pulse
//  dbg_req, dbg_addr, dbg_wd, dbg_we, dbg_rd, dbg_ack  same as cpu_* for debug port
//  mem_addr   out  ADDR_W  memory address
//  mem_wd     out  DATA_W  memory write data
//  mem_we     out  2       memory write enable, same encoding as *_we
//  mem_rd     in   DATA_W  memory read data
//  grant      out  2       one-hot owner {dbg,cpu}; 00 when IDLE
//  err        out  1       sticky: set when an access with we=11 was granted
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0; starve_cnt=0; err=0; latches 0.
//  All outputs are registered. Arbitration happens only in IDLE.
//  IDLE: if dbg_req && (starve_cnt>=STARVE_LIMIT || !cpu_req) grant dbg; else if cpu_req grant cpu;
//   on grant latch addr/wd/we of winner, set grant, go ISSUE. No req: stay IDLE.
//  ISSUE (1 cycle): mem_addr/mem_wd driven from latches; mem_we=latched we (00 for reads and for 11).
//   Write -> RESP. Read -> WAIT with lat_cnt=MEM_LAT-1.
//  WAIT: mem_addr held, mem_we=00. When lat_cnt==0 capture mem_rd into read latch -> RESP,
//   else lat_cnt--. So data sampled exactly MEM_LAT cycles after ISSUE.
//  RESP (1 cycle): ack of granted requester=1, its *_rd=read latch (0 for writes); -> IDLE.
//   *_rd holds value until next capture; only meaningful with ack.
//  Latency, req high in IDLE cycle C: write ack in C+2; read ack in C+2+MEM_LAT.
//  mem_we asserted for exactly one cycle per write; never during WAIT/RESP/IDLE.
//  Requester must drop req in the cycle after ack; req high in IDLE is a new request.
//  Req deasserted mid-transaction: transaction completes, ack still pulses.
//  Inputs of the granted requester are ignored after latching in IDLE.
//  starve_cnt: +1 each cycle dbg_req=1 and dbg not in grant, saturating at STARVE_LIMIT;
//   cleared when dbg is granted or dbg_req=0.
//  we=11: treated as read (mem_we=00), err set; cleared only by reset.
//  Simultaneous cpu_req and dbg_req with starve_cnt<STARVE_LIMIT: CPU wins.
//  Reset mid-access: immediate IDLE, mem_we=0, no ack issued; aborted write not retried.
// STRUCTURE
//  Shared package mem_pkg: arb_state_t {IDLE,ISSUE,WAIT,RESP}; MEMW_READ=2'b00,
//   MEMW_WORD=2'b01, MEMW_BYTE=2'b10; GNT_CPU=2'b01, GNT_DBG=2'b10.
//  One sub-module: mem_arb_starve_cnt (saturating counter, inc/clr, at_limit output).
//  FSM, request latches, latency counter and read latch stay in this module.
// TESTING
//  1 cpu read addr 0x40, we=00, mem returns 0x1234_5678, MEM_LAT=1 -> cpu_ack in C+3, cpu_rd=0x12345678, grant=01.
//  2 cpu word write 0x80 data 0xDEADBEEF -> mem_we=01 one cycle in C+1 with that addr/data, cpu_ack C+2.
//  3 cpu and dbg both request from C, cpu re-requests each time -> cpu served; dbg granted once starve_cnt hits 8.
//  4 MEM_LAT=3 dbg read -> mem_addr stable 4 cycles, dbg_ack at C+5, dbg_rd = mem_rd of cycle C+4.
//  5 cpu_we=11 -> mem_we stays 00, err=1 and remains 1, cpu_ack still pulses.
//  6 reset asserted during WAIT -> same cycle all outputs 0, state IDLE, no ack; next cpu_req served normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and encodings for the unified memory port arbiter.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   localparam logic [1:0] MEMW_READ = 2'b00;
   localparam logic [1:0] MEMW_WORD = 2'b01;
   localparam logic [1:0] MEMW_BYTE = 2'b10;
   localparam logic [1:0] MEMW_ILL  = 2'b11;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_CPU  = 2'b01;
   localparam logic [1:0] GNT_DBG  = 2'b10;

   function automatic logic is_write(input logic [1:0] we);
      return (we == MEMW_WORD) || (we == MEMW_BYTE);
   endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating wait counter for the debug requester; at_limit forces a debug grant.
module mem_arb_starve_cnt #(
   parameter int LIMIT = 8
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_at_limit
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != CW'(LIMIT))) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_at_limit = (r_cnt == CW'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between CPU and debug requesters and
// sequences each access IDLE -> ISSUE -> (WAIT) -> RESP with registered outputs.
//
// state | meaning
// IDLE  | no access in flight; arbitration and request latching
// ISSUE | address/data/we presented to memory for one cycle
// WAIT  | read latency countdown; mem_rd captured on terminal count
// RESP  | one-cycle ack to the granted requester
module mem_port_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MEM_LAT      = 1,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_cpu_req,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wd,
   input  logic [1:0]        i_cpu_we,
   output logic [DATA_W-1:0] o_cpu_rd,
   output logic              o_cpu_ack,
   input  logic              i_dbg_req,
   input  logic [ADDR_W-1:0] i_dbg_addr,
   input  logic [DATA_W-1:0] i_dbg_wd,
   input  logic [1:0]        i_dbg_we,
   output logic [DATA_W-1:0] o_dbg_rd,
   output logic              o_dbg_ack,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wd,
   output logic [1:0]        o_mem_we,
   input  logic [DATA_W-1:0] i_mem_rd,
   output logic [1:0]        o_grant,
   output logic              o_err
);

   localparam int LCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   arb_state_t        r_state, w_state_nxt;
   logic [LCW-1:0]    r_lat_cnt, w_lat_cnt_nxt;
   logic [1:0]        r_we, w_we_nxt;
   logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
   logic [DATA_W-1:0] r_mem_wd, w_mem_wd_nxt;
   logic [1:0]        r_mem_we, w_mem_we_nxt;
   logic [1:0]        r_grant, w_grant_nxt;
   logic [DATA_W-1:0] r_cpu_rd, w_cpu_rd_nxt;
   logic [DATA_W-1:0] r_dbg_rd, w_dbg_rd_nxt;
   logic              r_cpu_ack, w_cpu_ack_nxt;
   logic              r_dbg_ack, w_dbg_ack_nxt;
   logic              r_err, w_err_nxt;

   logic              w_at_limit;
   logic              w_dbg_win;
   logic              w_cpu_win;
   logic              w_finish;
   logic [DATA_W-1:0] w_resp_data;

   assign w_dbg_win = (r_state == IDLE) && i_dbg_req && (w_at_limit || !i_cpu_req);
   assign w_cpu_win = (r_state == IDLE) && i_cpu_req && !w_dbg_win;

   mem_arb_starve_cnt #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve_cnt (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_inc      (i_dbg_req && (r_grant != GNT_DBG)),
      .i_clr      (!i_dbg_req || w_dbg_win),
      .o_at_limit (w_at_limit)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_lat_cnt  <= '0;
         r_we       <= MEMW_READ;
         r_mem_addr <= '0;
         r_mem_wd   <= '0;
         r_mem_we   <= MEMW_READ;
         r_grant    <= GNT_NONE;
         r_cpu_rd   <= '0;
         r_dbg_rd   <= '0;
         r_cpu_ack  <= 1'b0;
         r_dbg_ack  <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_lat_cnt  <= w_lat_cnt_nxt;
         r_we       <= w_we_nxt;
         r_mem_addr <= w_mem_addr_nxt;
         r_mem_wd   <= w_mem_wd_nxt;
         r_mem_we   <= w_mem_we_nxt;
         r_grant    <= w_grant_nxt;
         r_cpu_rd   <= w_cpu_rd_nxt;
         r_dbg_rd   <= w_dbg_rd_nxt;
         r_cpu_ack  <= w_cpu_ack_nxt;
         r_dbg_ack  <= w_dbg_ack_nxt;
         r_err      <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_dbg_win || w_cpu_win) w_state_nxt = ISSUE;
         ISSUE:   w_state_nxt = is_write(r_we) ? RESP : WAIT;
         WAIT:    if (r_lat_cnt == '0) w_state_nxt = RESP;
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs are computed one cycle ahead so every port comes straight from a flop.
   always_comb begin
      w_lat_cnt_nxt  = r_lat_cnt;
      w_we_nxt       = r_we;
      w_mem_addr_nxt = r_mem_addr;
      w_mem_wd_nxt   = r_mem_wd;
      w_mem_we_nxt   = MEMW_READ;
      w_grant_nxt    = r_grant;
      w_cpu_rd_nxt   = r_cpu_rd;
      w_dbg_rd_nxt   = r_dbg_rd;
      w_cpu_ack_nxt  = 1'b0;
      w_dbg_ack_nxt  = 1'b0;
      w_err_nxt      = r_err;
      w_finish       = 1'b0;
      w_resp_data    = '0;

      case (r_state)
         IDLE: begin
            if (w_dbg_win) begin
               w_grant_nxt    = GNT_DBG;
               w_we_nxt       = i_dbg_we;
               w_mem_addr_nxt = i_dbg_addr;
               w_mem_wd_nxt   = i_dbg_wd;
            end else if (w_cpu_win) begin
               w_grant_nxt    = GNT_CPU;
               w_we_nxt       = i_cpu_we;
               w_mem_addr_nxt = i_cpu_addr;
               w_mem_wd_nxt   = i_cpu_wd;
            end
            if (w_dbg_win || w_cpu_win) begin
               if (is_write(w_we_nxt)) w_mem_we_nxt = w_we_nxt;
               if (w_we_nxt == MEMW_ILL) w_err_nxt = 1'b1;
            end
         end
         ISSUE: begin
            if (is_write(r_we)) w_finish = 1'b1;
            else                w_lat_cnt_nxt = LCW'(MEM_LAT - 1);
         end
         WAIT: begin
            if (r_lat_cnt == '0) begin
               w_finish    = 1'b1;
               w_resp_data = i_mem_rd;
            end else begin
               w_lat_cnt_nxt = r_lat_cnt - LCW'(1);
            end
         end
         RESP:    w_grant_nxt = GNT_NONE;
         default: ;
      endcase

      if (w_finish) begin
         if (r_grant == GNT_DBG) begin
            w_dbg_ack_nxt = 1'b1;
            w_dbg_rd_nxt  = w_resp_data;
         end else begin
            w_cpu_ack_nxt = 1'b1;
            w_cpu_rd_nxt  = w_resp_data;
         end
      end
   end

   assign o_cpu_rd   = r_cpu_rd;
   assign o_cpu_ack  = r_cpu_ack;
   assign o_dbg_rd   = r_dbg_rd;
   assign o_dbg_ack  = r_dbg_ack;
   assign o_mem_addr = r_mem_addr;
   assign o_mem_wd   = r_mem_wd;
   assign o_mem_we   = r_mem_we;
   assign o_grant    = r_grant;
   assign o_err      = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives two arbiters (MEM_LAT 1 and 3) with shared stimulus and checks both
// against a transaction-timing reference model.
module tb_mem_port_arbiter;
   import mem_pkg::*;

   localparam int LIM = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic cpu_req = 1'b0, dbg_req = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wd = '0, dbg_addr = '0, dbg_wd = '0, mem_rd = '0;
   logic [1:0]  cpu_we = '0, dbg_we = '0;

   logic [31:0] cpu_rd_w [2];
   logic [31:0] dbg_rd_w [2];
   logic [31:0] mem_addr_w [2];
   logic [31:0] mem_wd_w [2];
   logic        cpu_ack_w [2];
   logic        dbg_ack_w [2];
   logic        err_w [2];
   logic [1:0]  mem_we_w [2];
   logic [1:0]  grant_w [2];

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_LIMIT(LIM)) dut_a (
      .i_clk(clk), .i_reset(rst),
      .i_cpu_req(cpu_req), .i_cpu_addr(cpu_addr), .i_cpu_wd(cpu_wd), .i_cpu_we(cpu_we),
      .o_cpu_rd(cpu_rd_w[0]), .o_cpu_ack(cpu_ack_w[0]),
      .i_dbg_req(dbg_req), .i_dbg_addr(dbg_addr), .i_dbg_wd(dbg_wd), .i_dbg_we(dbg_we),
      .o_dbg_rd(dbg_rd_w[0]), .o_dbg_ack(dbg_ack_w[0]),
      .o_mem_addr(mem_addr_w[0]), .o_mem_wd(mem_wd_w[0]), .o_mem_we(mem_we_w[0]),
      .i_mem_rd(mem_rd), .o_grant(grant_w[0]), .o_err(err_w[0]));

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_LIMIT(LIM)) dut_b (
      .i_clk(clk), .i_reset(rst),
      .i_cpu_req(cpu_req), .i_cpu_addr(cpu_addr), .i_cpu_wd(cpu_wd), .i_cpu_we(cpu_we),
      .o_cpu_rd(cpu_rd_w[1]), .o_cpu_ack(cpu_ack_w[1]),
      .i_dbg_req(dbg_req), .i_dbg_addr(dbg_addr), .i_dbg_wd(dbg_wd), .i_dbg_we(dbg_we),
      .o_dbg_rd(dbg_rd_w[1]), .o_dbg_ack(dbg_ack_w[1]),
      .o_mem_addr(mem_addr_w[1]), .o_mem_wd(mem_wd_w[1]), .o_mem_we(mem_we_w[1]),
      .i_mem_rd(mem_rd), .o_grant(grant_w[1]), .o_err(err_w[1]));

   int n_assert = 0;
   int n_fail   = 0;
   int t        = 0;
   bit rand_mem = 1'b0;
   logic [31:0] hist [0:4095];

   // Reference model: one transaction record per DUT, granted in cycle m_g, acked in m_r.
   int          m_g [2];
   int          m_r [2];
   logic [1:0]  m_own [2];
   logic [1:0]  m_we [2];
   logic [31:0] m_addr [2];
   logic [31:0] m_wd [2];
   int          m_starve [2];
   logic        m_err [2];

   function automatic int lat(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s dut%0d cycle %0d observed=%h expected=%h", tag, k, t, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_g[k] = -100; m_r[k] = -100; m_own[k] = 2'b00; m_we[k] = 2'b00;
         m_addr[k] = '0; m_wd[k] = '0; m_starve[k] = 0; m_err[k] = 1'b0;
      end
   endtask

   task automatic check_dut(input int k);
      bit busy, wr, ackn;
      logic [1:0]  eg, ewe;
      logic [31:0] erd;
      busy = (m_g[k] < t) && (t <= m_r[k]);
      wr   = (m_we[k] == MEMW_WORD) || (m_we[k] == MEMW_BYTE);
      ackn = busy && (t == m_r[k]);
      eg   = busy ? m_own[k] : 2'b00;
      ewe  = (busy && (t == m_g[k] + 1) && wr) ? m_we[k] : MEMW_READ;
      chk("grant",   k, 32'(grant_w[k]),   32'(eg));
      chk("mem_we",  k, 32'(mem_we_w[k]),  32'(ewe));
      chk("cpu_ack", k, 32'(cpu_ack_w[k]), 32'(ackn && (m_own[k] == GNT_CPU)));
      chk("dbg_ack", k, 32'(dbg_ack_w[k]), 32'(ackn && (m_own[k] == GNT_DBG)));
      chk("err",     k, 32'(err_w[k]),     32'(m_err[k]));
      if (ackn) begin
         erd = wr ? 32'h0 : hist[m_g[k] + 1 + lat(k)];
         if (m_own[k] == GNT_CPU) chk("cpu_rd", k, cpu_rd_w[k], erd);
         else                     chk("dbg_rd", k, dbg_rd_w[k], erd);
      end
      if (busy && (t < m_r[k])) chk("mem_addr", k, mem_addr_w[k], m_addr[k]);
      if (busy && (t == m_g[k] + 1)) chk("mem_wd", k, mem_wd_w[k], m_wd[k]);
   endtask

   task automatic model_update(input int k);
      bit idle, dbg_in_grant, dwin, granted, wr;
      idle         = !((m_g[k] < t) && (t <= m_r[k]));
      dbg_in_grant = !idle && (m_own[k] == GNT_DBG);
      dwin = 1'b0; granted = 1'b0;
      if (idle) begin
         if (dbg_req && ((m_starve[k] >= LIM) || !cpu_req)) begin
            dwin = 1'b1; granted = 1'b1;
            m_own[k] = GNT_DBG; m_we[k] = dbg_we; m_addr[k] = dbg_addr; m_wd[k] = dbg_wd;
         end else if (cpu_req) begin
            granted = 1'b1;
            m_own[k] = GNT_CPU; m_we[k] = cpu_we; m_addr[k] = cpu_addr; m_wd[k] = cpu_wd;
         end
         if (granted) begin
            wr = (m_we[k] == MEMW_WORD) || (m_we[k] == MEMW_BYTE);
            m_g[k] = t;
            m_r[k] = t + 2 + (wr ? 0 : lat(k));
            if (m_we[k] == MEMW_ILL) m_err[k] = 1'b1;
         end
      end
      if (!dbg_req || dwin)                           m_starve[k] = 0;
      else if (!dbg_in_grant && (m_starve[k] < LIM))  m_starve[k]++;
   endtask

   // Called at posedge+1 with this cycle's inputs already driven.
   task automatic tick();
      if (rand_mem) mem_rd = $urandom;
      hist[t] = mem_rd;
      check_dut(0);
      check_dut(1);
      model_update(0);
      model_update(1);
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic idle_cycles(input int n);
      cpu_req = 1'b0; dbg_req = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cpu_req = 1'b0; dbg_req = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_grant",    k, 32'(grant_w[k]),   32'h0);
         chk("rst_mem_we",   k, 32'(mem_we_w[k]),  32'h0);
         chk("rst_cpu_ack",  k, 32'(cpu_ack_w[k]), 32'h0);
         chk("rst_dbg_ack",  k, 32'(dbg_ack_w[k]), 32'h0);
         chk("rst_err",      k, 32'(err_w[k]),     32'h0);
         chk("rst_cpu_rd",   k, cpu_rd_w[k],       32'h0);
         chk("rst_dbg_rd",   k, dbg_rd_w[k],       32'h0);
         chk("rst_mem_addr", k, mem_addr_w[k],     32'h0);
         chk("rst_mem_wd",   k, mem_wd_w[k],       32'h0);
      end
      model_reset();
      @(posedge clk);
      #1;
      t++;
      rst = 1'b0;
   endtask

   int c0;

   initial begin
      model_reset();
      #1;
      do_reset();
      idle_cycles(2);

      // CPU read, MEM_LAT=1: ack three cycles after request
      mem_rd = 32'h1234_5678;
      cpu_req = 1'b1; cpu_we = MEMW_READ; cpu_addr = 32'h40; cpu_wd = 32'h0;
      c0 = t;
      for (int i = 0; i < 3; i++) tick();
      chk("t1_ack",   0, 32'(cpu_ack_w[0]), 32'h1);
      chk("t1_rd",    0, cpu_rd_w[0],       32'h1234_5678);
      chk("t1_grant", 0, 32'(grant_w[0]),   32'(GNT_CPU));
      tick();
      idle_cycles(6);

      // CPU word write
      cpu_req = 1'b1; cpu_we = MEMW_WORD; cpu_addr = 32'h80; cpu_wd = 32'hDEAD_BEEF;
      tick();
      chk("t2_mem_we",   0, 32'(mem_we_w[0]), 32'(MEMW_WORD));
      chk("t2_mem_addr", 0, mem_addr_w[0],    32'h80);
      chk("t2_mem_wd",   0, mem_wd_w[0],      32'hDEAD_BEEF);
      tick();
      chk("t2_ack", 0, 32'(cpu_ack_w[0]), 32'h1);
      idle_cycles(6);

      // Both requesting continuously: debug wins once the starve count saturates
      rand_mem = 1'b1;
      cpu_req = 1'b1; cpu_we = MEMW_WORD; cpu_addr = 32'h200; cpu_wd = 32'h5555_AAAA;
      dbg_req = 1'b1; dbg_we = MEMW_READ; dbg_addr = 32'h300; dbg_wd = 32'h0;
      tick();
      chk("t3_first_grant", 0, 32'(grant_w[0]), 32'(GNT_CPU));
      for (int i = 0; i < 9; i++) tick();
      chk("t3_dbg_grant_a", 0, 32'(grant_w[0]), 32'(GNT_DBG));
      chk("t3_dbg_grant_b", 1, 32'(grant_w[1]), 32'(GNT_DBG));
      for (int i = 0; i < 30; i++) tick();
      idle_cycles(8);

      // Illegal we=11: read behaviour, sticky error, ack still issued
      cpu_req = 1'b1; cpu_we = MEMW_ILL; cpu_addr = 32'h44; cpu_wd = 32'hFFFF_0000;
      tick();
      chk("t5_mem_we", 0, 32'(mem_we_w[0]), 32'(MEMW_READ));
      chk("t5_err",    0, 32'(err_w[0]),    32'h1);
      tick(); tick();
      chk("t5_ack", 0, 32'(cpu_ack_w[0]), 32'h1);
      idle_cycles(8);
      chk("t5_err_sticky", 0, 32'(err_w[0]), 32'h1);

      // Debug read on the MEM_LAT=3 instance; request dropped after one cycle
      dbg_req = 1'b1; dbg_we = MEMW_READ; dbg_addr = 32'h100;
      c0 = t;
      tick();
      dbg_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("t4_addr_hold", 1, mem_addr_w[1], 32'h100);
         tick();
      end
      chk("t4_ack", 1, 32'(dbg_ack_w[1]), 32'h1);
      chk("t4_rd",  1, dbg_rd_w[1],       hist[c0 + 4]);
      idle_cycles(6);

      // Reset while the MEM_LAT=3 instance is waiting on a read
      cpu_req = 1'b1; cpu_we = MEMW_READ; cpu_addr = 32'h500;
      tick();
      cpu_req = 1'b0;
      tick(); tick();
      do_reset();
      idle_cycles(3);
      cpu_req = 1'b1; cpu_we = MEMW_WORD; cpu_addr = 32'h600; cpu_wd = 32'h0BAD_F00D;
      tick();
      cpu_req = 1'b0;
      idle_cycles(8);

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         cpu_req  = ($urandom_range(0, 3) != 0);
         dbg_req  = ($urandom_range(0, 2) != 0);
         cpu_we   = ($urandom_range(0, 15) == 0) ? MEMW_ILL : 2'($urandom_range(0, 2));
         dbg_we   = 2'($urandom_range(0, 2));
         cpu_addr = $urandom; cpu_wd = $urandom;
         dbg_addr = $urandom; dbg_wd = $urandom;
         tick();
      end
      idle_cycles(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
